// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle processor control unit.
// Sequences FETCH/DECODE/EXEC/WB/MEMACC/MEMWB per instruction, with a
// memory wait-state handshake, configurable opcode width and an
// illegal-opcode trap. All outputs are combinational from the current
// state, the captured opcode and mem_ready.
module multicycle_ctrl #(
    parameter int OPW      = 4,
    parameter int MEM_WAIT = 1,
    parameter int TRAP_EN  = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           w1,
    output logic           w2,
    output logic           pcwritecond,
    output logic           pcwrite,
    output logic           iord,
    output logic           memread,
    output logic           memwrite,
    output logic           irwrite,
    output logic [1:0]     memtoreg,
    output logic           A,
    output logic           B,
    output logic [2:0]     C,
    output logic [1:0]     pcsource,
    output logic [3:0]     aluop,
    output logic           ccpcinit,
    output logic [OPW-1:0] opcodereg,
    output logic [2:0]     curstate,
    output logic           illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_MEMACC = 3'd4,
        S_MEMWB  = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [OPW-1:0] r_opcodereg;
    logic           r_illegal;
    logic           r_ccpcinit;
    logic           w_rdy;
    logic           w_hi_nz;
    logic           w_illegal;

    // Opcode bits above the 4-bit base field must be zero to be legal.
    generate
        if (OPW > 4) begin : g_wide
            assign w_hi_nz = |opcode[OPW-1:4];
        end else begin : g_narrow
            assign w_hi_nz = 1'b0;
        end
    endgenerate

    assign w_illegal = w_hi_nz || (opcode[3:0] == 4'hE) || (opcode[3:0] == 4'hF);
    assign w_rdy     = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    assign curstate  = r_state;
    assign opcodereg = r_opcodereg;
    assign illegal   = r_illegal;
    assign ccpcinit  = r_ccpcinit;

    // State register, opcode capture on leaving DECODE, sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_opcodereg <= '0;
            r_illegal   <= 1'b0;
            r_ccpcinit  <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_ccpcinit <= 1'b0;
            if (r_state == S_DECODE) begin
                r_opcodereg <= opcode;
                if (w_illegal) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    // Next-state and control outputs; everything is held at 0 while reset is high.
    always_comb begin
        w_next      = r_state;
        w1          = 1'b0;
        w2          = 1'b0;
        pcwritecond = 1'b0;
        pcwrite     = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 2'b00;
        A           = 1'b0;
        B           = 1'b0;
        C           = 3'b000;
        pcsource    = 2'b00;
        aluop       = 4'b0000;

        case (r_state)
            S_FETCH: begin
                memread = 1'b1;
                aluop   = 4'b1111;
                pcwrite = w_rdy;
                irwrite = w_rdy;
                if (w_rdy) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                C     = 3'b001;
                aluop = 4'b1100;
                if (!w_illegal) begin
                    w_next = S_EXEC;
                end else if (TRAP_EN != 0) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC: begin
                A     = 1'b1;
                aluop = r_opcodereg[3:0];
                case (r_opcodereg[3:0])
                    4'h0, 4'h1, 4'h2, 4'h3: begin
                        B      = 1'b1;
                        C      = 3'b000;
                        w_next = S_WB;
                    end
                    4'h4, 4'h5, 4'h6, 4'h7: begin
                        B      = 1'b1;
                        C      = 3'b011;
                        w_next = S_WB;
                    end
                    4'h8, 4'h9: begin
                        C      = 3'b010;
                        w_next = S_MEMACC;
                    end
                    4'hA: begin
                        B           = 1'b1;
                        C           = 3'b010;
                        pcwritecond = 1'b1;
                        pcsource    = 2'b10;
                        w_next      = S_FETCH;
                    end
                    4'hB: begin
                        C      = 3'b100;
                        w_next = S_WB;
                    end
                    4'hC: begin
                        C        = 3'b010;
                        pcwrite  = 1'b1;
                        pcsource = 2'b01;
                        w_next   = S_FETCH;
                    end
                    4'hD: begin
                        C        = 3'b010;
                        w1       = 1'b1;
                        memtoreg = 2'b10;
                        pcwrite  = 1'b1;
                        pcsource = 2'b01;
                        aluop    = 4'b1101;
                        w_next   = S_FETCH;
                    end
                    default: begin
                        w_next = S_FETCH;
                    end
                endcase
            end
            S_WB: begin
                w1     = 1'b1;
                aluop  = 4'b1110;
                w2     = (r_opcodereg[3:0] == 4'h3);
                w_next = S_FETCH;
                if ((r_opcodereg[3:0] <= 4'h5) || (r_opcodereg[3:0] == 4'hB)) begin
                    memtoreg = 2'b01;
                end
            end
            S_MEMACC: begin
                iord = 1'b1;
                if (r_opcodereg[3:0] == 4'h8) begin
                    memread = 1'b1;
                    if (w_rdy) begin
                        w_next = S_MEMWB;
                    end
                end else begin
                    memwrite = w_rdy;
                    if (w_rdy) begin
                        w_next = S_FETCH;
                    end
                end
            end
            S_MEMWB: begin
                w1       = 1'b1;
                memtoreg = 2'b00;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (reset) begin
            w1          = 1'b0;
            w2          = 1'b0;
            pcwritecond = 1'b0;
            pcwrite     = 1'b0;
            iord        = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            irwrite     = 1'b0;
            memtoreg    = 2'b00;
            A           = 1'b0;
            B           = 1'b0;
            C           = 3'b000;
            pcsource    = 2'b00;
            aluop       = 4'b0000;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: default instance (OPW=4, waits
// honoured, trap enabled) plus a wide-opcode instance with TRAP_EN=0 and
// MEM_WAIT=0.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0 signals
    logic       r0, rdy0;
    logic [3:0] op0;
    logic       w1_0, w2_0, pcwc0, pcw0, iord0, mr0, mw0, irw0;
    logic [1:0] mtr0, pcs0;
    logic       A0, B0, cc0, ill0;
    logic [2:0] C0, cs0;
    logic [3:0] alu0, opr0;

    // Instance 1 signals
    logic       r1, rdy1;
    logic [5:0] op1;
    logic       w1_1, w2_1, pcwc1, pcw1, iord1, mr1, mw1, irw1;
    logic [1:0] mtr1, pcs1;
    logic       A1, B1, cc1, ill1;
    logic [2:0] C1, cs1;
    logic [3:0] alu1;
    logic [5:0] opr1;

    multicycle_ctrl #(.OPW(4), .MEM_WAIT(1), .TRAP_EN(1)) u0 (
        .clk(clk), .reset(r0), .opcode(op0), .mem_ready(rdy0),
        .w1(w1_0), .w2(w2_0), .pcwritecond(pcwc0), .pcwrite(pcw0),
        .iord(iord0), .memread(mr0), .memwrite(mw0), .irwrite(irw0),
        .memtoreg(mtr0), .A(A0), .B(B0), .C(C0), .pcsource(pcs0),
        .aluop(alu0), .ccpcinit(cc0), .opcodereg(opr0), .curstate(cs0),
        .illegal(ill0)
    );

    multicycle_ctrl #(.OPW(6), .MEM_WAIT(0), .TRAP_EN(0)) u1 (
        .clk(clk), .reset(r1), .opcode(op1), .mem_ready(rdy1),
        .w1(w1_1), .w2(w2_1), .pcwritecond(pcwc1), .pcwrite(pcw1),
        .iord(iord1), .memread(mr1), .memwrite(mw1), .irwrite(irw1),
        .memtoreg(mtr1), .A(A1), .B(B1), .C(C1), .pcsource(pcs1),
        .aluop(alu1), .ccpcinit(cc1), .opcodereg(opr1), .curstate(cs1),
        .illegal(ill1)
    );

    // Snapshots taken by run_instr
    logic       ex_A, ex_B, ex_pcwc, ex_pcw, ex_w1;
    logic [2:0] ex_C;
    logic [1:0] ex_pcs, ex_mtr, wb_mtr, mwb_mtr;
    logic [3:0] ex_alu;
    logic       wb_w1, wb_w2, mwb_w1;
    int cnt_w1, cnt_pcw, cnt_irw, cnt_mw, cnt_mr;
    int ncyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction on u0 with mem_ready=1, starting in FETCH.
    task automatic run_instr(input logic [3:0] op, output int n);
        ex_A = 0; ex_B = 0; ex_pcwc = 0; ex_pcw = 0; ex_w1 = 0; ex_C = 0;
        ex_pcs = 0; ex_mtr = 0; ex_alu = 0; wb_mtr = 0; wb_w1 = 0; wb_w2 = 0;
        mwb_w1 = 0; mwb_mtr = 2'b11;
        cnt_w1 = 0; cnt_pcw = 0; cnt_irw = 0; cnt_mw = 0; cnt_mr = 0;
        n = 0;
        op0 = op;
        rdy0 = 1'b1;
        do begin
            #1;
            if (cs0 == 3'd2) begin
                ex_A = A0; ex_B = B0; ex_C = C0; ex_pcs = pcs0; ex_pcwc = pcwc0;
                ex_pcw = pcw0; ex_w1 = w1_0; ex_mtr = mtr0; ex_alu = alu0;
            end
            if (cs0 == 3'd3) begin
                wb_w1 = w1_0; wb_w2 = w2_0; wb_mtr = mtr0;
            end
            if (cs0 == 3'd5) begin
                mwb_w1 = w1_0; mwb_mtr = mtr0;
            end
            cnt_w1  += int'(w1_0);
            cnt_pcw += int'(pcw0);
            cnt_irw += int'(irw0);
            cnt_mw  += int'(mw0);
            cnt_mr  += int'(mr0);
            cyc();
            n++;
        end while (cs0 !== 3'd0 && n < 20);
    endtask

    logic [2:0] exp_st [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
    int bad;

    initial begin
        r0 = 1'b1; op0 = 4'h0; rdy0 = 1'b1;
        r1 = 1'b1; op1 = 6'h00; rdy1 = 1'b0;
        cyc(); cyc();

        // Reset state
        chk("rst_state", cs0, 0);
        chk("rst_ccpcinit", cc0, 1);
        chk("rst_opcodereg", opr0, 0);
        chk("rst_illegal", ill0, 0);
        chk("rst_memread_forced", mr0, 0);

        // ALU opcode 0, step by step
        r0 = 1'b0;
        #1;
        chk("fetch_memread", mr0, 1);
        chk("fetch_aluop", alu0, 4'hF);
        chk("fetch_irwrite", irw0, 1);
        chk("fetch_ccpcinit_still", cc0, 1);
        cyc();
        chk("dec_state", cs0, 1);
        chk("ccpcinit_cleared", cc0, 0);
        chk("dec_aluop", alu0, 4'hC);
        chk("dec_C", C0, 1);
        chk("dec_w1", w1_0, 0);
        cyc();
        chk("ex_state", cs0, 2);
        chk("ex_aluop", alu0, 0);
        chk("ex_AB", {A0, B0}, 2'b11);
        chk("ex_C", C0, 0);
        cyc();
        chk("wb_state", cs0, 3);
        chk("wb_w1", w1_0, 1);
        chk("wb_memtoreg", mtr0, 1);
        chk("wb_aluop", alu0, 4'hE);
        cyc();
        chk("alu_back_fetch", cs0, 0);

        // Opcode 3: dual write
        run_instr(4'h3, ncyc);
        chk("op3_cycles", ncyc, 4);
        chk("op3_w1w2", {wb_w1, wb_w2}, 2'b11);
        chk("op3_memtoreg", wb_mtr, 1);

        // Opcode 6: shift group
        run_instr(4'h6, ncyc);
        chk("op6_cycles", ncyc, 4);
        chk("op6_exC", ex_C, 3);
        chk("op6_memtoreg", wb_mtr, 0);
        chk("op6_w2", wb_w2, 0);

        // Immediate
        run_instr(4'hB, ncyc);
        chk("imm_cycles", ncyc, 4);
        chk("imm_exBC", {ex_B, ex_C}, 4'b0100);
        chk("imm_memtoreg", wb_mtr, 1);

        // Store, zero wait
        run_instr(4'h9, ncyc);
        chk("st_cycles", ncyc, 4);
        chk("st_memwrite_cnt", cnt_mw, 1);
        chk("st_w1_cnt", cnt_w1, 0);

        // Load, zero wait
        run_instr(4'h8, ncyc);
        chk("ld_cycles", ncyc, 5);
        chk("ld_mwb", {mwb_w1, mwb_mtr}, 3'b100);
        chk("ld_w1_cnt", cnt_w1, 1);

        // Branch
        run_instr(4'hA, ncyc);
        chk("br_cycles", ncyc, 3);
        chk("br_pcsource", ex_pcs, 2);
        chk("br_pcwc_pcw", {ex_pcwc, ex_pcw}, 2'b10);
        chk("br_pcwrite_cnt", cnt_pcw, 1);

        // Jump
        run_instr(4'hC, ncyc);
        chk("jmp_cycles", ncyc, 3);
        chk("jmp_pcsource", ex_pcs, 1);
        chk("jmp_pcwrite_cnt", cnt_pcw, 2);

        // Link-and-jump
        run_instr(4'hD, ncyc);
        chk("lnk_cycles", ncyc, 3);
        chk("lnk_pcsource", ex_pcs, 1);
        chk("lnk_w1_mtr", {ex_w1, ex_mtr}, 3'b110);
        chk("lnk_aluop", ex_alu, 4'hD);
        chk("lnk_w1_cnt", cnt_w1, 1);

        // Load with 2 FETCH waits and 3 MEMACC waits
        op0 = 4'h8;
        cnt_w1 = 0; cnt_pcw = 0; cnt_irw = 0; cnt_mr = 0;
        for (int n = 0; n < 10; n++) begin
            rdy0 = !(n == 0 || n == 1 || n == 5 || n == 6 || n == 7);
            #1;
            chk("ldw_state", cs0, exp_st[n]);
            if (n == 9) chk("ldw_mwb_mtr", {w1_0, mtr0}, 3'b100);
            cnt_w1  += int'(w1_0);
            cnt_pcw += int'(pcw0);
            cnt_irw += int'(irw0);
            cnt_mr  += int'(mr0);
            cyc();
        end
        chk("ldw_done", cs0, 0);
        chk("ldw_memread_cnt", cnt_mr, 7);
        chk("ldw_irwrite_cnt", cnt_irw, 1);
        chk("ldw_pcwrite_cnt", cnt_pcw, 1);
        chk("ldw_w1_cnt", cnt_w1, 1);

        // Illegal opcode trap
        op0 = 4'hE; rdy0 = 1'b1;
        cyc();
        chk("trap_dec", cs0, 1);
        cyc();
        chk("trap_state", cs0, 6);
        chk("trap_illegal", ill0, 1);
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            rdy0 = 1'($urandom);
            op0 = 4'($urandom);
            #1;
            if (cs0 !== 3'd6 || ill0 !== 1'b1 ||
                (w1_0 | w2_0 | pcwc0 | pcw0 | iord0 | mr0 | mw0 | irw0) !== 1'b0)
                bad++;
            cyc();
        end
        chk("trap_hold_bad", bad, 0);
        r0 = 1'b1; op0 = 4'h9; rdy0 = 1'b1;
        cyc();
        chk("trap_rst_state", cs0, 0);
        chk("trap_rst_illegal", ill0, 0);
        chk("trap_rst_ccpcinit", cc0, 1);
        r0 = 1'b0;

        // Store aborted by reset in MEMACC
        cyc(); cyc(); cyc();
        rdy0 = 1'b0;
        #1;
        chk("sta_memacc", cs0, 4);
        chk("sta_iord", iord0, 1);
        chk("sta_wait_memwrite", mw0, 0);
        cyc();
        r0 = 1'b1;
        #1;
        chk("sta_rst_memwrite", mw0, 0);
        rdy0 = 1'b1;
        #1;
        chk("sta_rst_rdy_memwrite", mw0, 0);
        cyc();
        chk("sta_after_state", cs0, 0);
        chk("sta_after_ccpcinit", cc0, 1);
        chk("sta_after_memwrite", mw0, 0);
        r0 = 1'b0;

        // Wide opcode, TRAP_EN=0, MEM_WAIT=0 (mem_ready tied low)
        r1 = 1'b0; op1 = 6'h10; rdy1 = 1'b0;
        #1;
        chk("nt_fetch_pcwrite", pcw1, 1);
        cyc();
        chk("nt_dec_state", cs1, 1);
        chk("nt_dec_strobes", {w1_1, w2_1, pcwc1, pcw1, iord1, mr1, mw1, irw1}, 0);
        cyc();
        chk("nt_back_fetch", cs1, 0);
        chk("nt_opcodereg", opr1, 6'h10);
        op1 = 6'h05;
        ncyc = 0;
        do begin
            cyc();
            ncyc++;
        end while (cs1 !== 3'd0 && ncyc < 20);
        chk("nt_alu_cycles", ncyc, 4);
        chk("nt_opcodereg_legal", opr1, 6'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
